// File: rtl/mem_arbiter.sv
// SRAM arbiter between a CPU port and a 4-deep loader write FIFO.
// Optional macro MEM_ARBITER_ROM_WP_EN blocks CPU writes to the low 64 KiB.
module mem_arbiter #(
  parameter int unsigned ACCW = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpuRd,
  input  logic        cpuWr,
  input  logic [18:0] cpuA,
  input  logic [7:0]  cpuD,
  output logic [7:0]  cpuQ,
  output logic        cpuAck,
  input  logic        iniW,
  input  logic [18:0] iniA,
  input  logic [7:0]  iniD,
  output logic        iniFull,
  output logic        iniOvf,
  output logic [18:0] sramA,
  output logic [7:0]  sramD,
  input  logic [7:0]  sramQ,
  output logic        sramWe,
  output logic        sramOe,
  output logic        busy
);

  localparam int unsigned AW    = 19;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;
  localparam int unsigned TW    = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [TW-1:0]   acc_cnt_q, acc_cnt_d;
  logic            last_ldr_q, last_ldr_d;
  logic            own_cpu_q, own_cpu_d;
  logic            rd_q, rd_d;
  logic [AW-1:0]   sram_a_q, sram_a_d;
  logic [DW-1:0]   sram_d_q, sram_d_d;
  logic            we_q, we_d;
  logic            oe_q, oe_d;
  logic [DW-1:0]   cpu_q_q, cpu_q_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;

  logic [AW+DW-1:0] fifo_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             cpu_req_c, ldr_req_c, full_c, wp_c;
  logic             push_c, pop_c, grant_ldr_c;
  logic [AW+DW-1:0] head_c;

  assign cpu_req_c = cpuRd | cpuWr;
  assign ldr_req_c = (cnt_q != '0);
  assign full_c    = (cnt_q == CW'(DEPTH));
  assign head_c    = fifo_q[rd_ptr_q];

  // Write-protect only applies to pure CPU writes; a simultaneous read wins.
`ifdef MEM_ARBITER_ROM_WP_EN
  assign wp_c = ~cpuRd & (cpuA[18:16] == 3'd0);
`else
  assign wp_c = 1'b0;
`endif

  // A push into a full FIFO survives only when the head is popped that cycle.
  assign push_c   = iniW & (~full_c | pop_c);
  assign cnt_d    = cnt_q + CW'(push_c) - CW'(pop_c);
  assign wr_ptr_d = wr_ptr_q + PW'(push_c);
  assign rd_ptr_d = rd_ptr_q + PW'(pop_c);
  assign ovf_d    = ovf_q | (iniW & full_c & ~pop_c);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    last_ldr_d  = last_ldr_q;
    own_cpu_d   = own_cpu_q;
    rd_d        = rd_q;
    sram_a_d    = sram_a_q;
    sram_d_d    = sram_d_q;
    we_d        = we_q;
    oe_d        = oe_q;
    cpu_q_d     = cpu_q_q;
    ack_d       = 1'b0;
    busy_d      = busy_q;
    pop_c       = 1'b0;
    grant_ldr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ldr_req_c || cpu_req_c) begin
          // Nearly-full FIFO pre-empts; otherwise ties alternate.
          grant_ldr_c = (cnt_q >= CW'(3)) |
                        (ldr_req_c & (~cpu_req_c | ~last_ldr_q));
          pop_c      = grant_ldr_c;
          state_d    = ST_ACC;
          acc_cnt_d  = TW'(ACCW - 1);
          last_ldr_d = grant_ldr_c;
          own_cpu_d  = ~grant_ldr_c;
          busy_d     = 1'b1;
          if (grant_ldr_c) begin
            sram_a_d = head_c[AW+DW-1:DW];
            sram_d_d = head_c[DW-1:0];
            rd_d     = 1'b0;
            we_d     = 1'b0;
            oe_d     = 1'b1;
          end else begin
            sram_a_d = cpuA;
            sram_d_d = cpuD;
            rd_d     = cpuRd;
            we_d     = cpuRd | wp_c;
            oe_d     = ~cpuRd;
          end
        end
      end
      ST_ACC: begin
        if (acc_cnt_q == '0) begin
          state_d = ST_REL;
          we_d    = 1'b1;
          oe_d    = 1'b1;
          ack_d   = own_cpu_q;
          if (own_cpu_q && rd_q) cpu_q_d = sramQ;
        end else begin
          acc_cnt_d = acc_cnt_q - TW'(1);
        end
      end
      ST_REL: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        we_d    = 1'b1;
        oe_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      acc_cnt_q  <= '0;
      last_ldr_q <= 1'b0;
      own_cpu_q  <= 1'b0;
      rd_q       <= 1'b0;
      sram_a_q   <= '0;
      sram_d_q   <= '0;
      we_q       <= 1'b1;
      oe_q       <= 1'b1;
      cpu_q_q    <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_cnt_q  <= acc_cnt_d;
      last_ldr_q <= last_ldr_d;
      own_cpu_q  <= own_cpu_d;
      rd_q       <= rd_d;
      sram_a_q   <= sram_a_d;
      sram_d_q   <= sram_d_d;
      we_q       <= we_d;
      oe_q       <= oe_d;
      cpu_q_q    <= cpu_q_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
    end else if (push_c) begin
      fifo_q[wr_ptr_q] <= {iniA, iniD};
    end
  end

  assign cpuQ    = cpu_q_q;
  assign cpuAck  = ack_q;
  assign iniFull = full_c;
  assign iniOvf  = ovf_q;
  assign sramA   = sram_a_q;
  assign sramD   = sram_d_q;
  assign sramWe  = we_q;
  assign sramOe  = oe_q;
  assign busy    = busy_q;

endmodule
